// File: rtl/cnn_stream_loader.sv
// Byte-stream front end for the CNN core: frames commands into the image, kernel and FC arrays,
// strobes the core's write and start inputs, then returns the core result on a handshake.
module cnn_stream_loader #(
  parameter int IMAGE_WIDTH       = 12,
  parameter int IMAGE_HEIGHT      = 12,
  parameter int KERNEL_SIZE       = 3,
  parameter int NUM_FEATURES      = 2,
  parameter int FLATTENED_LENGTH  = 50,
  parameter int FC_DATA_WIDTH     = 8,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int RUN_CYCLES        = 112
) (
  input  logic                         clk_i,
  input  logic                         rst_cnn,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [7:0]                   s_data_i,
  output logic                         r_valid_o,
  input  logic                         r_ready_i,
  output logic [OUTPUT_DATA_WIDTH-1:0] r_data_o,
  output logic                         bad_opcode_o,
  output logic signed [1:0]            image_input_o [IMAGE_HEIGHT][IMAGE_WIDTH],
  output logic signed [1:0]            feature_weights_input_o [KERNEL_SIZE*KERNEL_SIZE],
  output logic [$clog2(NUM_FEATURES):0] feature_writeAddr_o,
  output logic                         feature_WrEn_o,
  output logic [FC_DATA_WIDTH-1:0]     fullyconnected_weights_input_o [FLATTENED_LENGTH],
  output logic                         fullyconnected_WrEn_o,
  output logic                         convolution_enable_o,
  input  logic [OUTPUT_DATA_WIDTH-1:0] cnn_output_i
);

  localparam int KK  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW  = $clog2(FLATTENED_LENGTH);
  localparam int KW  = $clog2(KK);
  localparam int RW  = $clog2(IMAGE_HEIGHT);
  localparam int CLW = $clog2(IMAGE_WIDTH);
  localparam int FAW = $clog2(NUM_FEATURES) + 1;
  localparam int RCW = $clog2(RUN_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_IMG, S_FADDR, S_FW, S_WR_F, S_FC, S_WR_FC, S_START, S_WAIT, S_RESULT
  } state_e;

  state_e state_q, state_d;
  logic   fire;

  logic signed [1:0]            image_q [IMAGE_HEIGHT][IMAGE_WIDTH];
  logic signed [1:0]            fw_q    [KK];
  logic [FC_DATA_WIDTH-1:0]     fc_q    [FLATTENED_LENGTH];
  logic [CW-1:0]                cnt_q;
  logic [RW-1:0]                row_q;
  logic [CLW-1:0]               col_q;
  logic [RCW-1:0]               run_q;
  logic [FAW-1:0]               fIdx_q;
  logic                         fIdxValid_q;
  logic [OUTPUT_DATA_WIDTH-1:0] rData_q;
  logic                         badOp_q, featWrEn_q, fcWrEn_q, convEn_q;

  always_ff @(posedge clk_i or negedge rst_cnn) begin
    if (!rst_cnn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s_ready_o = 1'b0;
    r_valid_o = 1'b0;
    case (state_q)
      S_IDLE, S_IMG, S_FADDR, S_FW, S_FC: s_ready_o = 1'b1;
      S_RESULT:                           r_valid_o = 1'b1;
      default: ;
    endcase
    fire = s_valid_i && s_ready_o;
    case (state_q)
      S_IDLE:
        if (fire) begin
          case (s_data_i)
            8'h01:   state_d = S_IMG;
            8'h02:   state_d = S_FADDR;
            8'h03:   state_d = S_FC;
            8'h04:   state_d = S_START;
            default: state_d = S_IDLE;
          endcase
        end
      S_IMG:
        if (fire && row_q == RW'(IMAGE_HEIGHT - 1) && col_q == CLW'(IMAGE_WIDTH - 1))
          state_d = S_IDLE;
      S_FADDR: if (fire) state_d = S_FW;
      S_FW:    if (fire && cnt_q == CW'(KK - 1)) state_d = S_WR_F;
      S_FC:    if (fire && cnt_q == CW'(FLATTENED_LENGTH - 1)) state_d = S_WR_FC;
      S_WR_F, S_WR_FC: state_d = S_IDLE;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (run_q == '0) state_d = S_RESULT;
      S_RESULT: if (r_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Core strobes are decoded from the next state so each is a clean register output.
  always_ff @(posedge clk_i or negedge rst_cnn) begin
    if (!rst_cnn) begin
      for (int r = 0; r < IMAGE_HEIGHT; r++)
        for (int c = 0; c < IMAGE_WIDTH; c++) image_q[r][c] <= '0;
      for (int i = 0; i < KK; i++) fw_q[i] <= '0;
      for (int i = 0; i < FLATTENED_LENGTH; i++) fc_q[i] <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      run_q       <= '0;
      fIdx_q      <= '0;
      fIdxValid_q <= 1'b0;
      rData_q     <= '0;
      badOp_q     <= 1'b0;
      featWrEn_q  <= 1'b1;
      fcWrEn_q    <= 1'b1;
      convEn_q    <= 1'b1;
    end else begin
      badOp_q    <= (state_q == S_IDLE) && fire && (s_data_i == 8'h00 || s_data_i > 8'h04);
      featWrEn_q <= !(state_d == S_WR_F && fIdxValid_q);
      fcWrEn_q   <= !(state_d == S_WR_FC);
      convEn_q   <= !(state_d == S_START);
      case (state_q)
        S_IDLE:
          if (fire) begin
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
          end
        S_IMG:
          if (fire) begin
            image_q[row_q][col_q] <= s_data_i[1:0];
            if (col_q == CLW'(IMAGE_WIDTH - 1)) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        S_FADDR:
          if (fire) begin
            fIdx_q      <= s_data_i[FAW-1:0];
            fIdxValid_q <= s_data_i < 8'(NUM_FEATURES);
          end
        S_FW:
          if (fire) begin
            fw_q[cnt_q[KW-1:0]] <= s_data_i[1:0];
            cnt_q <= cnt_q + 1'b1;
          end
        S_FC:
          if (fire) begin
            fc_q[cnt_q] <= FC_DATA_WIDTH'(s_data_i);
            cnt_q <= cnt_q + 1'b1;
          end
        S_START: run_q <= RCW'(RUN_CYCLES - 1);
        S_WAIT:
          if (run_q == '0) rData_q <= cnn_output_i;
          else             run_q   <= run_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign image_input_o                  = image_q;
  assign feature_weights_input_o        = fw_q;
  assign fullyconnected_weights_input_o = fc_q;
  assign feature_writeAddr_o            = fIdx_q;
  assign feature_WrEn_o                 = featWrEn_q;
  assign fullyconnected_WrEn_o          = fcWrEn_q;
  assign convolution_enable_o           = convEn_q;
  assign bad_opcode_o                   = badOp_q;
  assign r_data_o                       = rData_q;

endmodule

// File: tb/tb_cnn_stream_loader.sv
// Directed bench for cnn_stream_loader: framed loads, strobe counts, run timing, result hold and reset abort.
module tb_cnn_stream_loader;

  localparam int IW = 12, IH = 12, KS = 3, NF = 2, FL = 50, RUN = 112;
  localparam int KK = KS * KS;

  logic        clk, rstCnn, sValid, sReady, rValid, rReady, badOpcode;
  logic [7:0]  sData;
  logic [31:0] rData, cnnOutput;
  logic signed [1:0] imageInput [IH][IW];
  logic signed [1:0] featWeights [KK];
  logic [1:0]  featAddr;
  logic        featWrEn, fcWrEn, convEn;
  logic [7:0]  fcWeights [FL];

  int checkCount = 0, passCount = 0;
  int featLow = 0, fcLow = 0, convLow = 0, badHigh = 0;
  logic [1:0] featAddrSeen = '0;

  cnn_stream_loader dut (
    .clk_i(clk), .rst_cnn(rstCnn), .s_valid_i(sValid), .s_ready_o(sReady), .s_data_i(sData),
    .r_valid_o(rValid), .r_ready_i(rReady), .r_data_o(rData), .bad_opcode_o(badOpcode),
    .image_input_o(imageInput), .feature_weights_input_o(featWeights),
    .feature_writeAddr_o(featAddr), .feature_WrEn_o(featWrEn),
    .fullyconnected_weights_input_o(fcWeights), .fullyconnected_WrEn_o(fcWrEn),
    .convolution_enable_o(convEn), .cnn_output_i(cnnOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally strobe activity once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (!featWrEn) begin
      featLow++;
      featAddrSeen = featAddr;
    end
    if (!fcWrEn) fcLow++;
    if (!convEn) convLow++;
    if (badOpcode) badHigh++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the byte has transferred.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int t = 0;
    sValid = 1'b0;
    repeat (gap) @(negedge clk);
    sValid = 1'b1;
    sData  = b;
    while (!sReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) checkOutput("s_ready_wait", {31'b0, sReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    sValid = 1'b0;
  endtask

  initial begin
    int n, f0, golden, t;
    rstCnn = 1'b0; sValid = 1'b0; sData = '0; rReady = 1'b0; cnnOutput = '0;
    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_r_valid", {31'b0, rValid}, 32'd0);
    checkOutput("rst_bad_opcode", {31'b0, badOpcode}, 32'd0);
    checkOutput("rst_feature_WrEn", {31'b0, featWrEn}, 32'd1);
    checkOutput("rst_fc_WrEn", {31'b0, fcWrEn}, 32'd1);
    checkOutput("rst_conv_enable", {31'b0, convEn}, 32'd1);
    checkOutput("rst_r_data", rData, 32'd0);
    checkOutput("rst_image", {30'b0, imageInput[5][7]}, 32'd0);
    checkOutput("rst_fc", {24'b0, fcWeights[49]}, 32'd0);
    rstCnn = 1'b1;
    @(negedge clk);
    checkOutput("rst_s_ready", {31'b0, sReady}, 32'd1);

    $display("[TB] image load with gaps");
    applyStimulus(8'h01, 0);
    for (int i = 0; i < IH * IW; i++) applyStimulus(8'(i), $urandom_range(0, 2));
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        checkOutput($sformatf("image_%0d_%0d", r, c), {30'b0, imageInput[r][c]}, (12 * r + c) & 3);
    checkOutput("image_1_1", {30'b0, imageInput[1][1]}, 32'd1);
    checkOutput("image_back_idle", {31'b0, sReady}, 32'd1);

    $display("[TB] feature load");
    f0 = featLow;
    applyStimulus(8'h02, 0);
    applyStimulus(8'h01, 0);
    for (int i = 0; i < KK; i++) applyStimulus(8'hFF, 0);
    repeat (2) @(negedge clk);
    checkOutput("feat_strobe_count", featLow - f0, 32'd1);
    checkOutput("feat_addr", {30'b0, featAddrSeen}, 32'd1);
    for (int i = 0; i < KK; i++)
      checkOutput($sformatf("feat_w_%0d", i), {30'b0, featWeights[i]}, 32'd3);
    f0 = featLow;
    applyStimulus(8'h02, 0);
    applyStimulus(8'h05, 0);
    for (int i = 0; i < KK; i++) applyStimulus(8'h01, 0);
    repeat (2) @(negedge clk);
    checkOutput("feat_bad_index_no_strobe", featLow - f0, 32'd0);
    checkOutput("feat_bad_index_idle", {31'b0, sReady}, 32'd1);

    $display("[TB] fc load");
    f0 = fcLow;
    applyStimulus(8'h03, 0);
    for (int i = 0; i < FL; i++) applyStimulus(8'h02, i % 2);
    repeat (2) @(negedge clk);
    checkOutput("fc_strobe_count", fcLow - f0, 32'd1);
    for (int i = 0; i < FL; i++)
      checkOutput($sformatf("fc_w_%0d", i), {24'b0, fcWeights[i]}, 32'd2);

    $display("[TB] run");
    applyStimulus(8'h01, 0);
    for (int i = 0; i < IH * IW; i++) applyStimulus(8'h01, 0);
    for (int k = 0; k < NF; k++) begin
      applyStimulus(8'h02, 0);
      applyStimulus(8'(k), 0);
      for (int i = 0; i < KK; i++) applyStimulus(8'h01, 0);
    end
    applyStimulus(8'h03, 0);
    for (int i = 0; i < FL; i++) applyStimulus(8'h01, 0);
    @(negedge clk);
    checkOutput("run_image_kept", {30'b0, imageInput[11][11]}, 32'd1);
    checkOutput("run_kernel", {30'b0, featWeights[8]}, 32'd1);
    golden = KK * FL;
    cnnOutput = 32'(golden);
    f0 = convLow;
    applyStimulus(8'h04, 0);
    checkOutput("conv_enable_low", {31'b0, convEn}, 32'd0);
    checkOutput("start_s_ready", {31'b0, sReady}, 32'd0);
    n = 0;
    while (!rValid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run_latency", n, RUN + 1);
    checkOutput("conv_low_cycles", convLow - f0, 32'd1);
    checkOutput("r_data_golden", rData, 32'd450);
    cnnOutput = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_r_data_%0d", i), rData, 32'd450);
      checkOutput($sformatf("hold_s_ready_%0d", i), {31'b0, sReady}, 32'd0);
      checkOutput($sformatf("hold_r_valid_%0d", i), {31'b0, rValid}, 32'd1);
    end
    rReady = 1'b1;
    @(negedge clk);
    rReady = 1'b0;
    checkOutput("consumed_r_valid", {31'b0, rValid}, 32'd0);
    checkOutput("consumed_s_ready", {31'b0, sReady}, 32'd1);

    $display("[TB] bad opcode and reset mid-wait");
    f0 = badHigh;
    applyStimulus(8'h7E, 0);
    checkOutput("bad_opcode_pulse", {31'b0, badOpcode}, 32'd1);
    @(negedge clk);
    checkOutput("bad_opcode_cleared", {31'b0, badOpcode}, 32'd0);
    checkOutput("bad_opcode_count", badHigh - f0, 32'd1);
    checkOutput("bad_opcode_idle", {31'b0, sReady}, 32'd1);
    applyStimulus(8'h04, 0);
    repeat (20) @(negedge clk);
    checkOutput("mid_wait_s_ready", {31'b0, sReady}, 32'd0);
    #2 rstCnn = 1'b0;
    #1;
    checkOutput("abort_r_valid", {31'b0, rValid}, 32'd0);
    checkOutput("abort_s_ready", {31'b0, sReady}, 32'd1);
    checkOutput("abort_conv_enable", {31'b0, convEn}, 32'd1);
    checkOutput("abort_image", {30'b0, imageInput[0][0]}, 32'd0);
    checkOutput("abort_r_data", rData, 32'd0);
    @(negedge clk);
    rstCnn = 1'b1;
    t = 0;
    for (int i = 0; i < RUN + 40; i++) begin
      @(negedge clk);
      if (rValid) t++;
    end
    checkOutput("abort_no_result", t, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
